hash_window_combine: RTL

Downstream consumer of the per-byte multiplier-hash stage. Takes the four 24-bit partial products of one payload byte times the 64-bit hash constant and reassembles the 64-bit product. Folds the last NGRAM products into a rolling (buzhash-style) window hash. Emits one HASH_BITS-wide table index per byte once the window is full; this feeds the hash-table lookup stage of the string matcher.

---
 rtl/hash_pkg.sv | 18 +
 rtl/prod_delay_line.sv | 36 +++
 rtl/hash_window_combine.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/hash_pkg.sv
// Shared types, defaults and helpers for the hash window stages.
package hash_pkg;

    localparam int HASH_NGRAM_DEF = 8;
    localparam int HASH_BITS_DEF  = 12;

    typedef logic [63:0] prod_t;
    typedef logic [23:0] term_t;

    // Rotate a 64-bit value left by 0..63; a shift of 64 on the right
    // half yields zero, so sh == 0 returns x unchanged.
    function automatic prod_t rotl64(input prod_t x, input logic [5:0] sh);
        logic [6:0] inv;
        inv = 7'd64 - {1'b0, sh};
        return (x << sh) | (x >> inv);
    endfunction

endpackage

// File: rtl/prod_delay_line.sv
// NGRAM-deep shift register of 64-bit products; shifts only when enabled
// and exposes the oldest entry. Contents are never cleared: the consumer
// masks stale entries with its own fill count.
module prod_delay_line
    import hash_pkg::*;
#(
    parameter int DEPTH = HASH_NGRAM_DEF
) (
    input  logic  clk,
    input  logic  shift_en,
    input  prod_t din,
    output prod_t tail
);

    prod_t dl_q [DEPTH];
    prod_t dl_d [DEPTH];

    // Next contents: push din at the head, move every entry one deeper.
    always_comb begin
        dl_d = dl_q;
        if (shift_en) begin
            dl_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                dl_d[i] = dl_q[i-1];
            end
        end
    end

    // Storage register (no reset, stale data is masked downstream).
    always_ff @(posedge clk) begin
        dl_q <= dl_d;
    end

    assign tail = dl_q[DEPTH-1];

endmodule

// File: rtl/hash_window_combine.sv
// Reassembles the 64-bit byte*constant product from four 24-bit partial
// products, then folds the last NGRAM products into a rolling window hash.
// Optional statistics counters are built when HASH_WINDOW_STATS_EN is defined.
//
// Stream semantics: in_valid marks a beat; there is no ready, the block
// accepts one beat every cycle. in_sop/in_eop are only meaningful while
// in_valid is high. out_valid marks a full-window hash; out_eop marks the
// beat of an eop byte independently of out_valid. Latency is two cycles.
module hash_window_combine
    import hash_pkg::*;
#(
    parameter int NGRAM     = HASH_NGRAM_DEF,
    parameter int HASH_BITS = HASH_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_sop,
    input  logic                 in_eop,
    input  logic [23:0]          ab0,
    input  logic [23:0]          ab1,
    input  logic [23:0]          ab2,
    input  logic [23:0]          ab3,
    output logic                 out_valid,
    output logic [HASH_BITS-1:0] out_hash,
    output logic                 out_eop
`ifdef HASH_WINDOW_STATS_EN
    ,
    output logic [31:0]          stat_hash_cnt,
    output logic [31:0]          stat_short_cnt
`endif
);

    localparam logic [6:0] NGRAM_C  = 7'(NGRAM);
    localparam logic [5:0] TAIL_ROT = 6'(NGRAM % 64);

    // ---------------- stage 1: product reassembly ----------------
    logic [71:0] sum72;
    logic [7:0]  unused_sum_hi;
    logic        s1_valid_d, s1_valid_q;
    logic        s1_sop_d,   s1_sop_q;
    logic        s1_eop_d,   s1_eop_q;
    prod_t       s1_prod_d,  s1_prod_q;

    // Sum the weighted terms at full width; only the low 64 bits are kept.
    always_comb begin
        sum72      = {48'd0, ab0}
                   + {32'd0, ab1, 16'd0}
                   + {16'd0, ab2, 32'd0}
                   + {ab3, 48'd0};
        s1_prod_d  = sum72[63:0];
        s1_valid_d = in_valid;
        s1_sop_d   = in_valid & in_sop;
        s1_eop_d   = in_valid & in_eop;
    end

    assign unused_sum_hi = sum72[71:64];

    // Stage-1 pipeline register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sop_q   <= 1'b0;
            s1_eop_q   <= 1'b0;
            s1_prod_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sop_q   <= s1_sop_d;
            s1_eop_q   <= s1_eop_d;
            s1_prod_q  <= s1_prod_d;
        end
    end

    // ---------------- stage 2: rolling window ----------------
    prod_t      dl_tail;
    prod_t      tail_term;
    prod_t      h_d, h_q;
    logic [6:0] cnt_d, cnt_q;
    logic [6:0] cnt_upd;
    logic       out_valid_d, out_valid_q;
    logic       out_eop_d,   out_eop_q;

    prod_delay_line #(
        .DEPTH (NGRAM)
    ) u_dl (
        .clk      (clk),
        .shift_en (s1_valid_q),
        .din      (s1_prod_q),
        .tail     (dl_tail)
    );

    // Window update: restart on sop or empty window, otherwise rotate in the
    // new product and, once full, cancel the product leaving the window.
    always_comb begin
        h_d         = h_q;
        cnt_d       = cnt_q;
        cnt_upd     = cnt_q;
        tail_term   = '0;
        out_valid_d = 1'b0;
        out_eop_d   = 1'b0;
        if (s1_valid_q) begin
            if (s1_sop_q || (cnt_q == 7'd0)) begin
                h_d     = s1_prod_q;
                cnt_upd = 7'd1;
            end else begin
                if (cnt_q == NGRAM_C) begin
                    tail_term = rotl64(dl_tail, TAIL_ROT);
                end
                h_d     = rotl64(h_q, 6'd1) ^ s1_prod_q ^ tail_term;
                cnt_upd = (cnt_q == NGRAM_C) ? NGRAM_C : cnt_q + 7'd1;
            end
            out_valid_d = (cnt_upd == NGRAM_C);
            out_eop_d   = s1_eop_q;
            cnt_d       = s1_eop_q ? 7'd0 : cnt_upd;
        end
    end

    // Stage-2 state and output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_q         <= '0;
            cnt_q       <= 7'd0;
            out_valid_q <= 1'b0;
            out_eop_q   <= 1'b0;
        end else begin
            h_q         <= h_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_eop_q   <= out_eop_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_eop   = out_eop_q;
    assign out_hash  = h_q[63 -: HASH_BITS];

`ifdef HASH_WINDOW_STATS_EN
    logic [31:0] stat_hash_d,  stat_hash_q;
    logic [31:0] stat_short_d, stat_short_q;

    // Count full-window hashes and packets that ended before filling.
    always_comb begin
        stat_hash_d  = stat_hash_q;
        stat_short_d = stat_short_q;
        if (out_valid_d) begin
            stat_hash_d = stat_hash_q + 32'd1;
        end
        if (s1_valid_q && s1_eop_q && !out_valid_d) begin
            stat_short_d = stat_short_q + 32'd1;
        end
    end

    // Statistics counter register; wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_hash_q  <= 32'd0;
            stat_short_q <= 32'd0;
        end else begin
            stat_hash_q  <= stat_hash_d;
            stat_short_q <= stat_short_d;
        end
    end

    assign stat_hash_cnt  = stat_hash_q;
    assign stat_short_cnt = stat_short_q;
`endif

endmodule
